hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Sits in the ID stage, directly upstream of the EX-stage register forwarding logic.
- Detects hazards that forwarding cannot resolve:
  - load-use RAW on the integer or floating-point register bank;
  - RAW, WAW and structural hazards against one in-flight multi-cycle EX operation (integer div, fdiv, fsqrt).
- Holds PC and IF/ID, and injects a bubble into ID/EX until the hazard clears.
- Owns a small state machine tracking the outstanding multi-cycle destination register.

Parameters:
- MC_TIMEOUT, 64, cycles in BUSY without mc_done_i before the watchdog forces IDLE.
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk_i  input  1  core clock
- reset_i  input  1  asynchronous active-low reset
- id_rs1  input  5  rs1 of the instruction in ID
- id_rs2  input  5  rs2 of the instruction in ID
- id_rd  input  5  rd of the instruction in ID
- id_bank1  input  1  rs1 is in the FP bank
- id_bank2  input  1  rs2 is in the FP bank
- id_bank_rd  input  1  rd is in the FP bank
- id_wb  input  1  ID instruction writes rd (active-low)
- id_multicycle  input  1  ID instruction is a multi-cycle op
- idex_rd  input  5  rd in ID/EX
- idex_bank_rd  input  1  ID/EX rd is in the FP bank
- idex_wb  input  1  ID/EX writes rd (active-low)
- idex_mem_read  input  1  ID/EX is a load
- idex_multicycle  input  1  ID/EX holds a multi-cycle op entering EX
- mc_done_i  input  1  multi-cycle unit writes back its result this cycle
- flush_i  input  1  branch/trap flush of IF/ID and ID/EX
- pc_stall  output  1  hold PC
- ifid_stall  output  1  hold IF/ID
- idex_bubble  output  1  load NOP control into ID/EX
- mc_busy  output  1  a multi-cycle op is outstanding
- mc_timeout  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Register match rule, used everywhere below: indices equal AND bank bits equal AND (index != 0 OR bank bit = 1). FP f0 is a real register.
- Reset (reset_i low, asynchronous):
  - state = IDLE, scoreboard rd/bank = 0, watchdog counter = 0;
  - all outputs 0.
- Load-use (combinational):
  - Condition: idex_mem_read=1, idex_wb=0, and idex_rd matches id_rs1 or id_rs2.
  - Response: pc_stall = ifid_stall = idex_bubble = 1.
  - Exactly 1 stall cycle results, because the bubble clears idex_mem_read.
- State machine, two states:
  - IDLE -> BUSY when idex_multicycle=1 and flush_i=0. Latch sb_rd = idex_rd, sb_bank = idex_bank_rd, sb_valid = !idex_wb. Clear the counter.
  - BUSY -> IDLE on mc_done_i=1.
  - BUSY -> IDLE on watchdog expiry: counter == MC_TIMEOUT-1 without mc_done_i. mc_timeout pulses 1 cycle and the scoreboard clears.
  - BUSY: counter increments each cycle.
- mc_busy = (state == BUSY). The output is registered.
- BUSY hazards (combinational stall, same three stall outputs):
  - RAW: sb_valid and sb_rd matches id_rs1 or id_rs2.
  - WAW: sb_valid, id_wb=0, and sb_rd matches id_rd.
  - Structural: id_multicycle=1.
- Simultaneous events:
  - mc_done_i in the same cycle as a BUSY hazard: the stall is still asserted that cycle; it releases next cycle, when the register file or forwarding path holds the value.
  - mc_done_i in BUSY while idex_multicycle=1: cannot occur, because the structural stall prevents it. If it does occur, the new op wins: stay BUSY and reload the scoreboard.
  - flush_i: suppresses the IDLE->BUSY transition that cycle and forces all three stall outputs to 0. An already-BUSY operation is not cancelled and stays tracked.
  - Load-use and BUSY hazard together: outputs are simply ORed.
- Latency:
  - Stall outputs are combinational from the current state and ID/EX inputs.
  - State updates on the rising clk_i edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, add outputs:
  - perf_loaduse_cnt, 32 bits: count of load-use stall cycles;
  - perf_mc_cnt, 32 bits: count of BUSY-hazard stall cycles.
- Counters are saturating, reset to 0, and a cycle with both hazards increments both.
- When undefined, neither port nor counter logic exists, and the other outputs behave identically.

Test Plan:
- Load-use integer: ID/EX lw x5, ID add x6,x5,x1 -> stall outputs =1 for exactly 1 cycle, then 0. Repeat with rd=x0 -> no stall.
- Bank separation: ID/EX flw f5, ID add x6,x5,x1 -> no stall. ID/EX flw f0, ID fadd f1,f0,f2 -> 1-cycle stall.
- Multi-cycle RAW: fdiv f3 issues. ID fadd f4,f3,f1 stalls until mc_done_i at cycle 18, and releases in cycle 19. Meanwhile mc_busy=1 from cycle 1 through the mc_done_i cycle, and 0 in the cycle after it.
- Structural/WAW: while BUSY on div x7, ID div x8 stalls and ID addi x7 stalls, while ID addi x9 does not stall.
- Watchdog: BUSY with no mc_done_i -> mc_timeout pulses exactly once after 64 cycles, the state returns to IDLE, and a pending RAW stall releases.
- Reset/flush: reset_i low mid-BUSY -> all outputs 0 immediately, state IDLE. flush_i with idex_multicycle=1 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: load-use and multi-cycle EX RAW/WAW/structural stalls.
// Define HAZARD_PERF_EN to add saturating stall-cycle performance counters.
//
// state | meaning
// IDLE  | no multi-cycle operation outstanding
// BUSY  | a multi-cycle operation is in EX; sb_* holds its destination
module hazard_detection_unit #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_bank1,
  input  logic       id_bank2,
  input  logic       id_bank_rd,
  input  logic       id_wb,
  input  logic       id_multicycle,
  input  logic [4:0] idex_rd,
  input  logic       idex_bank_rd,
  input  logic       idex_wb,
  input  logic       idex_mem_read,
  input  logic       idex_multicycle,
  input  logic       mc_done_i,
  input  logic       flush_i,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_bubble,
  output logic       mc_busy,
  output logic       mc_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_loaduse_cnt,
  output logic [31:0] perf_mc_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [4:0]       sb_rd_q, sb_rd_d;
  logic             sb_bank_q, sb_bank_d;
  logic             sb_valid_q, sb_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire;
  logic             accept;

  logic load_use;
  logic raw_hazard;
  logic waw_hazard;
  logic busy_hazard;
  logic lu_stall;
  logic mc_stall;
  logic stall;

  // x0 is hardwired zero and never carries a dependency; f0 is a real register.
  function automatic logic reg_match(input logic [4:0] a_idx, input logic a_bank,
                                     input logic [4:0] b_idx, input logic b_bank);
    return (a_idx == b_idx) && (a_bank == b_bank) && ((a_idx != 5'd0) || a_bank);
  endfunction

  always_comb begin
    load_use = idex_mem_read && !idex_wb &&
               (reg_match(idex_rd, idex_bank_rd, id_rs1, id_bank1) ||
                reg_match(idex_rd, idex_bank_rd, id_rs2, id_bank2));
    raw_hazard = sb_valid_q &&
                 (reg_match(sb_rd_q, sb_bank_q, id_rs1, id_bank1) ||
                  reg_match(sb_rd_q, sb_bank_q, id_rs2, id_bank2));
    waw_hazard = sb_valid_q && !id_wb && reg_match(sb_rd_q, sb_bank_q, id_rd, id_bank_rd);
    busy_hazard = (state_q == BUSY) && (raw_hazard || waw_hazard || id_multicycle);
    lu_stall    = !flush_i && load_use;
    mc_stall    = !flush_i && busy_hazard;
    stall       = reset_i && (lu_stall || mc_stall);
  end

  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;
  assign mc_busy     = (state_q == BUSY);
  assign mc_timeout  = timeout_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      sb_rd_q    <= 5'd0;
      sb_bank_q  <= 1'b0;
      sb_valid_q <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sb_rd_q    <= sb_rd_d;
      sb_bank_q  <= sb_bank_d;
      sb_valid_q <= sb_valid_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sb_rd_d    = sb_rd_q;
    sb_bank_d  = sb_bank_q;
    sb_valid_d = sb_valid_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    expire     = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        accept = idex_multicycle && !flush_i;
      end
      BUSY: begin
        expire = !mc_done_i && (cnt_q == CNT_LAST);
        if (mc_done_i || expire) begin
          state_d    = IDLE;
          sb_rd_d    = 5'd0;
          sb_bank_d  = 1'b0;
          sb_valid_d = 1'b0;
          timeout_d  = expire;
          // Unit frees up this cycle, so an op entering EX takes it over.
          accept     = idex_multicycle && !flush_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d    = BUSY;
      sb_rd_d    = idex_rd;
      sb_bank_d  = idex_bank_rd;
      sb_valid_d = !idex_wb;
      cnt_d      = '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_loaduse_cnt <= 32'd0;
      perf_mc_cnt      <= 32'd0;
    end else begin
      if (lu_stall && (perf_loaduse_cnt != 32'hFFFF_FFFF))
        perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (mc_stall && (perf_mc_cnt != 32'hFFFF_FFFF))
        perf_mc_cnt <= perf_mc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit with a per-cycle behavioural model.
module tb_hazard_detection_unit;

  localparam int TIMEOUT_CYCLES = 64;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [4:0] id_rs1, id_rs2, id_rd, idex_rd;
  logic       id_bank1, id_bank2, id_bank_rd, id_wb, id_multicycle;
  logic       idex_bank_rd, idex_wb, idex_mem_read, idex_multicycle;
  logic       mc_done_i, flush_i;
  logic       pc_stall, ifid_stall, idex_bubble, mc_busy, mc_timeout;

  int total = 0;
  int bad = 0;
  int to_cnt;

  hazard_detection_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_bank1(id_bank1), .id_bank2(id_bank2), .id_bank_rd(id_bank_rd),
    .id_wb(id_wb), .id_multicycle(id_multicycle),
    .idex_rd(idex_rd), .idex_bank_rd(idex_bank_rd), .idex_wb(idex_wb),
    .idex_mem_read(idex_mem_read), .idex_multicycle(idex_multicycle),
    .mc_done_i(mc_done_i), .flush_i(flush_i),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding op is a record {rd, bank, writes}, aged in BUSY cycles from 1.
  bit         m_busy, m_valid, m_to;
  int         m_age;
  logic [4:0] m_rd;
  logic       m_bank;

  function automatic bit same_reg(input logic [4:0] a, input logic ba,
                                  input logic [4:0] b, input logic bb);
    return ({ba, a} == {bb, b}) && ({ba, a} != 6'd0);
  endfunction

  function automatic bit exp_stall();
    bit lu, bh;
    if (!reset_i || flush_i) return 1'b0;
    lu = idex_mem_read && !idex_wb &&
         (same_reg(idex_rd, idex_bank_rd, id_rs1, id_bank1) ||
          same_reg(idex_rd, idex_bank_rd, id_rs2, id_bank2));
    bh = m_busy && (id_multicycle ||
         (m_valid && (same_reg(m_rd, m_bank, id_rs1, id_bank1) ||
                      same_reg(m_rd, m_bank, id_rs2, id_bank2) ||
                      (!id_wb && same_reg(m_rd, m_bank, id_rd, id_bank_rd)))));
    return lu || bh;
  endfunction

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_busy = 0; m_valid = 0; m_to = 0; m_age = 0; m_rd = 0; m_bank = 0;
    end else begin
      bit expire, freed;
      expire = m_busy && !mc_done_i && (m_age == TIMEOUT_CYCLES);
      freed  = !m_busy || mc_done_i || expire;
      m_to   = expire;
      if (freed && idex_multicycle && !flush_i) begin
        m_busy = 1; m_age = 1; m_valid = !idex_wb; m_rd = idex_rd; m_bank = idex_bank_rd;
      end else if (m_busy && freed) begin
        m_busy = 0; m_valid = 0;
      end else if (m_busy) begin
        m_age++;
      end
    end
  end

  always @(negedge clk_i) begin
    bit s;
    s = exp_stall();
    chk("model_pc_stall", pc_stall, s);
    chk("model_ifid_stall", ifid_stall, s);
    chk("model_idex_bubble", idex_bubble, s);
    chk("model_mc_busy", mc_busy, m_busy);
    chk("model_mc_timeout", mc_timeout, m_to);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idex(input logic [4:0] rd, input logic bank, input logic wb_n,
                          input logic mem_rd, input logic multi);
    idex_rd = rd; idex_bank_rd = bank; idex_wb = wb_n;
    idex_mem_read = mem_rd; idex_multicycle = multi;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic b1, input logic [4:0] rs2,
                        input logic b2, input logic [4:0] rd, input logic brd,
                        input logic wb_n, input logic multi);
    id_rs1 = rs1; id_bank1 = b1; id_rs2 = rs2; id_bank2 = b2;
    id_rd = rd; id_bank_rd = brd; id_wb = wb_n; id_multicycle = multi;
  endtask

  task automatic idle();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    mc_done_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #1;
    chk({name, "_pc"}, pc_stall, exp);
    chk({name, "_ifid"}, ifid_stall, exp);
    chk({name, "_bubble"}, idex_bubble, exp);
  endtask

  initial begin
    idle();
    // Load-use pattern held during reset must not stall.
    set_idex(5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd5, 1'b0, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk_stall("rst_stall", 1'b0);
    chk("rst_busy", mc_busy, 1'b0);
    chk("rst_timeout", mc_timeout, 1'b0);
    #2 reset_i = 1'b1;
    idle();
    tick();

    // Load-use integer: lw x5 ; add x6,x5,x1
    set_idex(5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd5, 1'b0, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk_stall("lu_int", 1'b1);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_stall("lu_int_release", 1'b0);
    tick();
    // Same via rs2
    set_idex(5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd1, 1'b0, 5'd5, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk_stall("lu_rs2", 1'b1);
    tick();
    // lw x0 ; add x6,x0,x1 -> no stall
    set_idex(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd0, 1'b0, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk_stall("lu_x0", 1'b0);
    tick();

    // Bank separation: flw f5 ; add x6,x5,x1 -> no stall
    set_idex(5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    set_id(5'd5, 1'b0, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk_stall("bank_sep", 1'b0);
    tick();
    // flw f0 ; fadd f1,f0,f2 -> 1-cycle stall
    set_idex(5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    set_id(5'd0, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    chk_stall("lu_f0", 1'b1);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_stall("lu_f0_release", 1'b0);
    tick();
    // Flush masks a load-use stall
    set_idex(5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd5, 1'b0, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    chk_stall("lu_flush", 1'b0);
    tick();
    idle();
    tick();

    // Multi-cycle RAW: fdiv f3 enters EX in cycle 0, done in cycle 18
    set_idex(5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_stall("mc_c0", 1'b0);
    chk("mc_c0_busy", mc_busy, 1'b0);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_id(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      mc_done_i = (c == 18);
      chk_stall($sformatf("mc_raw_c%0d", c), 1'b1);
      chk($sformatf("mc_busy_c%0d", c), mc_busy, 1'b1);
      tick();
    end
    mc_done_i = 1'b0;
    chk_stall("mc_raw_c19", 1'b0);
    chk("mc_busy_c19", mc_busy, 1'b0);
    idle();
    tick();

    // Structural / WAW while BUSY on div x7
    set_idex(5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_id(5'd1, 1'b0, 5'd2, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
    chk_stall("struct_div", 1'b1);
    tick();
    set_id(5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    chk_stall("waw_x7", 1'b1);
    tick();
    set_id(5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_stall("waw_f7_other_bank", 1'b0);
    tick();
    set_id(5'd1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_stall("no_haz_x9", 1'b0);
    tick();
    // Flush masks the BUSY hazard but keeps the op tracked
    set_id(5'd7, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    chk_stall("busy_flush", 1'b0);
    tick();
    flush_i = 1'b0;
    chk("busy_after_flush", mc_busy, 1'b1);
    chk_stall("raw_after_flush", 1'b1);
    // New op wins when done coincides with another op entering EX: fdiv f3
    mc_done_i = 1'b1;
    set_idex(5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    mc_done_i = 1'b0;
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reload_busy", mc_busy, 1'b1);
    set_id(5'd7, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_stall("reload_old_rd", 1'b0);
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_stall("reload_new_rd", 1'b1);
    // Load-use and BUSY hazard together
    set_idex(5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    set_id(5'd3, 1'b1, 5'd5, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_stall("lu_and_busy", 1'b1);
    mc_done_i = 1'b1;
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("done_idle", mc_busy, 1'b0);
    tick();

    // Watchdog: fdiv f3 with no completion, RAW pending on f3
    to_cnt = 0;
    set_idex(5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_id(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
      #1;
      to_cnt += int'(mc_timeout);
      if (c == 1 || c == TIMEOUT_CYCLES) begin
        chk_stall($sformatf("wd_stall_c%0d", c), 1'b1);
        chk($sformatf("wd_to_c%0d", c), mc_timeout, 1'b0);
      end
      tick();
    end
    #1;
    to_cnt += int'(mc_timeout);
    chk("wd_fire", mc_timeout, 1'b1);
    chk("wd_idle", mc_busy, 1'b0);
    chk_stall("wd_release", 1'b0);
    tick();
    to_cnt += int'(mc_timeout);
    chk("wd_pulse_end", mc_timeout, 1'b0);
    tick();
    to_cnt += int'(mc_timeout);
    chk("wd_pulse_count", to_cnt, 1);
    idle();
    tick();

    // Async reset mid-BUSY on div x7
    set_idex(5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_idex(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_id(5'd7, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_stall("pre_reset_raw", 1'b1);
    reset_i = 1'b0;
    chk_stall("reset_stall", 1'b0);
    chk("reset_busy", mc_busy, 1'b0);
    chk("reset_timeout", mc_timeout, 1'b0);
    tick();
    #1 reset_i = 1'b1;
    chk_stall("post_reset_raw", 1'b0);
    chk("post_reset_busy", mc_busy, 1'b0);
    tick();

    // Flush with a multi-cycle op entering EX in IDLE stays IDLE
    idle();
    set_idex(5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    flush_i = 1'b1;
    tick();
    idle();
    chk("flush_stays_idle", mc_busy, 1'b0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
